// File: rtl/ex_mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_resp_if
// Brief    : EX1/EX3 load/store bus between the core and the scratchpad
//            responder.
// Revision : 1.0  initial release
// ============================================================================
interface ex_mem_resp_if;
    logic [47:0] memAddr;
    logic [7:0]  memOpm;
    logic [63:0] memDataOut;
    logic        pipeHold;
    logic        opBraFlush;
    logic [63:0] memDataIn;
    logic [63:0] memDataInB;
    logic [1:0]  memDataOK;

    modport master (
        output memAddr, memOpm, memDataOut, pipeHold, opBraFlush,
        input  memDataIn, memDataInB, memDataOK
    );

    modport slave (
        input  memAddr, memOpm, memDataOut, pipeHold, opBraFlush,
        output memDataIn, memDataInB, memDataOK
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_resp
// Brief    : Scratchpad data memory answering lane-1 loads/stores in EX3 with
//            wait states and fault status. JX2_MEMRESP_ALIGNCHK_EN turns
//            misaligned W/L/Q accesses into faults instead of masking them.
// Revision : 1.0  initial release
// ============================================================================
module ex_mem_resp #(
    parameter int          ADDR_BITS = 13,
    parameter int          WAIT_CYC  = 0,
    parameter logic [47:0] BASE_ADDR = 48'h0000_C000_0000
) (
    input  wire logic     clock,
    input  wire logic     reset,
    ex_mem_resp_if.slave  bus
);
    localparam int          c_IDX_BITS = ADDR_BITS - 3;
    localparam int          c_WORDS    = 1 << c_IDX_BITS;
    localparam logic [48:0] c_WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [48:0] c_WIN_HI   = c_WIN_LO + (49'd1 << ADDR_BITS);
    localparam logic [3:0]  c_WAIT     = 4'(WAIT_CYC);
    localparam logic [1:0]  c_OK_READY = 2'b00;
    localparam logic [1:0]  c_OK_IDLE  = 2'b01;
    localparam logic [1:0]  c_OK_HOLD  = 2'b10;
    localparam logic [1:0]  c_OK_FAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    logic [63:0] r_mem [0:c_WORDS-1];

    // Stage A (EX2)
    logic                  r_aValid, r_aLoad, r_aStore, r_aUnsigned;
    logic [1:0]            r_aSize;
    logic [47:0]           r_aAddr;
    logic [63:0]           r_aData;
    // Stage B (EX3)
    logic                  r_bValid, r_bStore, r_bFault, r_bCommitted;
    logic [c_IDX_BITS-1:0] r_bIdx;
    logic [7:0]            r_bBe;
    logic [63:0]           r_bWrData;
    logic [63:0]           r_memDataIn, r_memDataInB;
    state_t                r_state;
    logic [3:0]            r_waitCnt;

    logic                  w_inLoad, w_inStore, w_advance, w_commit;
    logic [2:0]            w_aSizeMask, w_aOff;
    logic [7:0]            w_aBeBase, w_aBe;
    logic [63:0]           w_aDataMask, w_aWrData, w_aRdWord, w_aWord;
    logic [63:0]           w_aShifted, w_aLoadData;
    logic [c_IDX_BITS-1:0] w_aIdx;
    logic                  w_aInWin, w_aMisalign, w_aFault;
    state_t                w_entryState, w_nextState;
    logic [3:0]            w_entryCnt, w_nextCnt;
    logic [1:0]            w_memDataOK;
    logic                  w_unusedOpm;

    assign w_unusedOpm = ^bus.memOpm[7:5];
    assign w_inLoad    = (bus.memOpm[4:3] == 2'b10);
    assign w_inStore   = (bus.memOpm[4:3] == 2'b01);
    assign w_advance   = !bus.pipeHold;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aValid    <= 1'b0;
            r_aLoad     <= 1'b0;
            r_aStore    <= 1'b0;
            r_aUnsigned <= 1'b0;
            r_aSize     <= 2'd0;
            r_aAddr     <= 48'd0;
            r_aData     <= 64'd0;
        end else if (w_advance) begin
            r_aValid    <= w_inLoad || w_inStore;
            r_aLoad     <= w_inLoad;
            r_aStore    <= w_inStore;
            r_aUnsigned <= bus.memOpm[2];
            r_aSize     <= bus.memOpm[1:0];
            r_aAddr     <= bus.memAddr;
            r_aData     <= bus.memDataOut;
        end
    end

    always_comb begin
        w_aSizeMask = 3'b000;
        w_aBeBase   = 8'h01;
        w_aDataMask = 64'h0000_0000_0000_00FF;
        case (r_aSize)
            2'd1: begin
                w_aSizeMask = 3'b001;
                w_aBeBase   = 8'h03;
                w_aDataMask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                w_aSizeMask = 3'b011;
                w_aBeBase   = 8'h0F;
                w_aDataMask = 64'h0000_0000_FFFF_FFFF;
            end
            2'd3: begin
                w_aSizeMask = 3'b111;
                w_aBeBase   = 8'hFF;
                w_aDataMask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            default: ;
        endcase
    end

    assign w_aOff      = r_aAddr[2:0] & ~w_aSizeMask;
    assign w_aMisalign = |(r_aAddr[2:0] & w_aSizeMask);
    assign w_aIdx      = r_aAddr[ADDR_BITS-1:3];
    assign w_aBe       = w_aBeBase << w_aOff;
    assign w_aWrData   = (r_aData & w_aDataMask) << {w_aOff, 3'b000};
    assign w_aInWin    = ({1'b0, r_aAddr} >= c_WIN_LO) && ({1'b0, r_aAddr} < c_WIN_HI);

`ifdef JX2_MEMRESP_ALIGNCHK_EN
    assign w_aFault = !w_aInWin || w_aMisalign;
`else
    assign w_aFault = !w_aInWin || (w_aMisalign && 1'b0);
`endif

    // A store committing this edge to the word A is reading must be seen by A
    assign w_aRdWord = r_mem[w_aIdx];
    always_comb begin
        w_aWord = w_aRdWord;
        if (w_commit && (r_bIdx == w_aIdx)) begin
            for (int i = 0; i < 8; i++) begin
                if (r_bBe[i]) begin
                    w_aWord[i*8 +: 8] = r_bWrData[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_aShifted  = w_aWord >> {w_aOff, 3'b000};
        w_aLoadData = w_aWord;
        case (r_aSize)
            2'd0: w_aLoadData = r_aUnsigned ? {56'd0, w_aShifted[7:0]}
                                            : {{56{w_aShifted[7]}}, w_aShifted[7:0]};
            2'd1: w_aLoadData = r_aUnsigned ? {48'd0, w_aShifted[15:0]}
                                            : {{48{w_aShifted[15]}}, w_aShifted[15:0]};
            2'd2: w_aLoadData = r_aUnsigned ? {32'd0, w_aShifted[31:0]}
                                            : {{32{w_aShifted[31]}}, w_aShifted[31:0]};
            default: w_aLoadData = w_aWord;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bValid     <= 1'b0;
            r_bStore     <= 1'b0;
            r_bFault     <= 1'b0;
            r_bCommitted <= 1'b0;
            r_bIdx       <= '0;
            r_bBe        <= 8'd0;
            r_bWrData    <= 64'd0;
            r_memDataIn  <= 64'd0;
            r_memDataInB <= 64'd0;
        end else if (w_advance) begin
            r_bValid     <= r_aValid;
            r_bStore     <= r_aStore;
            r_bFault     <= r_aValid && w_aFault;
            r_bCommitted <= 1'b0;
            r_bIdx       <= w_aIdx;
            r_bBe        <= w_aBe;
            r_bWrData    <= w_aWrData;
            if (r_aValid && !w_aFault) begin
                r_memDataInB <= w_aWord;
                if (r_aLoad) begin
                    r_memDataIn <= w_aLoadData;
                end
            end
        end else begin
            if (bus.opBraFlush) begin
                r_bValid <= 1'b0;
            end
            if (w_commit) begin
                r_bCommitted <= 1'b1;
            end
        end
    end

    // Only the first READY cycle of a store writes; a held pipe must not repeat it
    assign w_commit = r_bValid && r_bStore && !r_bFault && !r_bCommitted &&
                      (r_state == ST_DONE) && !bus.opBraFlush;

    always_ff @(posedge clock) begin
        if (!reset && w_commit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_bBe[i]) begin
                    r_mem[r_bIdx][i*8 +: 8] <= r_bWrData[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_entryState = ST_IDLE;
        w_entryCnt   = 4'd0;
        if (r_aValid) begin
            if (w_aFault) begin
                w_entryState = ST_FAULT;
            end else if (WAIT_CYC > 0) begin
                w_entryState = ST_WAIT;
                w_entryCnt   = 4'd1;
            end else begin
                w_entryState = ST_DONE;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_waitCnt;
        if (w_advance) begin
            w_nextState = w_entryState;
            w_nextCnt   = w_entryCnt;
        end else if (bus.opBraFlush) begin
            w_nextState = ST_IDLE;
            w_nextCnt   = 4'd0;
        end else if (r_state == ST_WAIT) begin
            if (r_waitCnt == c_WAIT) begin
                w_nextState = ST_DONE;
                w_nextCnt   = 4'd0;
            end else begin
                w_nextCnt = r_waitCnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
        end
    end

    always_comb begin
        w_memDataOK = c_OK_IDLE;
        if (!bus.opBraFlush) begin
            case (r_state)
                ST_WAIT:  w_memDataOK = c_OK_HOLD;
                ST_DONE:  w_memDataOK = c_OK_READY;
                ST_FAULT: w_memDataOK = c_OK_FAULT;
                default:  w_memDataOK = c_OK_IDLE;
            endcase
        end
    end

    assign bus.memDataOK  = w_memDataOK;
    assign bus.memDataIn  = r_memDataIn;
    assign bus.memDataInB = r_memDataInB;
endmodule
`default_nettype wire

// File: tb/tb_ex_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_resp
// Brief    : Directed vector bench for ex_mem_resp (WAIT_CYC=0 and 3 copies).
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_resp;
    localparam logic [47:0] c_BASE = 48'h0000_C000_0000;

    typedef struct {
        logic [7:0]  opm;
        logic [47:0] addr;
        logic [63:0] data;
        logic [1:0]  expOk;
        logic        chkData;
        logic [63:0] expData;
        logic        chkB;
        logic [63:0] expB;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    vec_t vecs [19];

    ex_mem_resp_if if0();
    ex_mem_resp_if if3();

    ex_mem_resp #(.ADDR_BITS(13), .WAIT_CYC(0), .BASE_ADDR(c_BASE)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    ex_mem_resp #(.ADDR_BITS(13), .WAIT_CYC(3), .BASE_ADDR(c_BASE)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (if3)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic [7:0] opm, input logic [47:0] addr, input logic [63:0] data);
        if0.memOpm     = opm;
        if0.memAddr    = addr;
        if0.memDataOut = data;
    endtask

    task automatic drive3(input logic [7:0] opm, input logic [47:0] addr, input logic [63:0] data);
        if3.memOpm     = opm;
        if3.memAddr    = addr;
        if3.memDataOut = data;
    endtask

    // Present one op to dut0; returns right after the edge that moves it into B
    task automatic op0(input logic [7:0] opm, input logic [47:0] addr, input logic [63:0] data);
        @(posedge clock); #1 drive0(opm, addr, data);
        @(posedge clock); #1 drive0(8'h00, c_BASE, 64'd0);
        @(posedge clock);
    endtask

    // One op through dut3 with the core freezing while HOLD/READY are shown
    task automatic opWait3(input string name, input logic [7:0] opm, input logic [47:0] addr,
                           input logic [63:0] data, input logic chkData, input logic [63:0] expData);
        @(posedge clock); #1 drive3(opm, addr, data);
        @(posedge clock); #1 drive3(8'h00, c_BASE, 64'd0);
        @(posedge clock); #1 if3.pipeHold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("%s_hold%0d", name, k), 64'(if3.memDataOK), 64'(2'b10));
            @(posedge clock);
        end
        @(negedge clock);
        check($sformatf("%s_ready", name), 64'(if3.memDataOK), 64'(2'b00));
        if (chkData) check($sformatf("%s_data", name), if3.memDataIn, expData);
        @(posedge clock); #1 if3.pipeHold = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check($sformatf("%s_idleAfter", name), 64'(if3.memDataOK), 64'(2'b01));
    endtask

    initial begin
        drive0(8'h00, c_BASE, 64'd0);
        drive3(8'h00, c_BASE, 64'd0);
        if0.pipeHold = 1'b0; if0.opBraFlush = 1'b0;
        if3.pipeHold = 1'b0; if3.opBraFlush = 1'b0;

        vecs[0]  = '{8'h0B, c_BASE + 48'h00,   64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 1'b1, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{8'h0B, c_BASE + 48'h10,   64'h1122_3344_5566_7788, 2'b00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[2]  = '{8'h13, c_BASE + 48'h10,   64'h0, 2'b00, 1'b1, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788};
        vecs[3]  = '{8'h08, c_BASE + 48'h13,   64'h80, 2'b00, 1'b1, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
        vecs[4]  = '{8'h10, c_BASE + 48'h13,   64'h0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 64'h1122_3344_8066_7788};
        vecs[5]  = '{8'h14, c_BASE + 48'h13,   64'h0, 2'b00, 1'b1, 64'h0000_0000_0000_0080, 1'b0, 64'h0};
        vecs[6]  = '{8'h11, c_BASE + 48'h12,   64'h0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_8066, 1'b0, 64'h0};
        vecs[7]  = '{8'h16, c_BASE + 48'h14,   64'h0, 2'b00, 1'b1, 64'h0000_0000_1122_3344, 1'b0, 64'h0};
        vecs[8]  = '{8'h12, c_BASE + 48'h10,   64'h0, 2'b00, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0, 64'h0};
        vecs[9]  = '{8'h00, c_BASE + 48'h10,   64'h0, 2'b01, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0, 64'h0};
        vecs[10] = '{8'h18, c_BASE + 48'h10,   64'h0, 2'b01, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0, 64'h0};
        vecs[11] = '{8'h13, c_BASE + 48'h2000, 64'h0, 2'b11, 1'b1, 64'hFFFF_FFFF_8066_7788, 1'b0, 64'h0};
        vecs[12] = '{8'h0B, c_BASE + 48'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[13] = '{8'h13, c_BASE - 48'h8,    64'h0, 2'b11, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[14] = '{8'h13, c_BASE + 48'h00,   64'h0, 2'b00, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 64'h0};
`ifdef JX2_MEMRESP_ALIGNCHK_EN
        vecs[15] = '{8'h11, c_BASE + 48'h11,   64'h0, 2'b11, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 64'h0};
`else
        vecs[15] = '{8'h11, c_BASE + 48'h11,   64'h0, 2'b00, 1'b1, 64'h0000_0000_0000_7788, 1'b0, 64'h0};
`endif
        vecs[16] = '{8'h09, c_BASE + 48'h16,   64'hFFFF_FFFF_FFFF_BEEF, 2'b00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[17] = '{8'h13, c_BASE + 48'h10,   64'h0, 2'b00, 1'b1, 64'hBEEF_3344_8066_7788, 1'b0, 64'h0};
        vecs[18] = '{8'h11, c_BASE + 48'h16,   64'h0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 64'h0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ok0",   64'(if0.memDataOK), 64'(2'b01));
        check("rst_data0", if0.memDataIn, 64'd0);
        check("rst_dataB0", if0.memDataInB, 64'd0);
        check("rst_ok3",   64'(if3.memDataOK), 64'(2'b01));

        for (int i = 0; i < 19; i++) begin
            op0(vecs[i].opm, vecs[i].addr, vecs[i].data);
            @(negedge clock);
            check($sformatf("vec%0d_ok", i), 64'(if0.memDataOK), 64'(vecs[i].expOk));
            if (vecs[i].chkData) check($sformatf("vec%0d_data", i), if0.memDataIn, vecs[i].expData);
            if (vecs[i].chkB) check($sformatf("vec%0d_dataB", i), if0.memDataInB, vecs[i].expB);
        end

        // Store L then load Q of the same word on the next cycle
        op0(8'h0B, c_BASE + 48'h20, 64'h0123_4567_89AB_CDEF);
        @(posedge clock); #1 drive0(8'h0A, c_BASE + 48'h20, 64'h0000_0000_DEAD_BEEF);
        @(posedge clock); #1 drive0(8'h13, c_BASE + 48'h20, 64'd0);
        @(posedge clock); #1 drive0(8'h00, c_BASE, 64'd0);
        @(negedge clock);
        check("byp_storeOk", 64'(if0.memDataOK), 64'(2'b00));
        @(posedge clock);
        @(negedge clock);
        check("byp_loadOk", 64'(if0.memDataOK), 64'(2'b00));
        check("byp_data",   if0.memDataIn,  64'h0123_4567_DEAD_BEEF);
        check("byp_dataB",  if0.memDataInB, 64'h0123_4567_DEAD_BEEF);

        // Flushed store must not reach memory
        op0(8'h0B, c_BASE + 48'h28, 64'h0F0F_0F0F_0F0F_0F0F);
        op0(8'h0B, c_BASE + 48'h28, 64'h5555_5555_5555_5555);
        #1 if0.opBraFlush = 1'b1;
        @(negedge clock);
        check("flush_storeOk", 64'(if0.memDataOK), 64'(2'b01));
        @(posedge clock); #1 if0.opBraFlush = 1'b0;
        op0(8'h13, c_BASE + 48'h28, 64'd0);
        @(negedge clock);
        check("flush_loadOk", 64'(if0.memDataOK), 64'(2'b00));
        check("flush_data",   if0.memDataIn, 64'h0F0F_0F0F_0F0F_0F0F);

        // Flush beats FAULT
        op0(8'h13, c_BASE + 48'h2000, 64'd0);
        #1 if0.opBraFlush = 1'b1;
        @(negedge clock);
        check("flush_faultOk", 64'(if0.memDataOK), 64'(2'b01));
        @(posedge clock); #1 if0.opBraFlush = 1'b0;

        // Wait-state copy
        opWait3("w3store", 8'h0B, c_BASE + 48'h30, 64'h7777_6666_5555_4444, 1'b0, 64'd0);
        opWait3("w3load",  8'h13, c_BASE + 48'h30, 64'd0, 1'b1, 64'h7777_6666_5555_4444);

        // Reset while a store sits in WAIT
        @(posedge clock); #1 drive3(8'h0B, c_BASE + 48'h30, 64'h9999_9999_9999_9999);
        @(posedge clock); #1 drive3(8'h00, c_BASE, 64'd0);
        @(posedge clock); #1 if3.pipeHold = 1'b1;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 begin reset = 1'b0; if3.pipeHold = 1'b0; end
        @(negedge clock);
        check("rstWait_ok", 64'(if3.memDataOK), 64'(2'b01));
        opWait3("w3after", 8'h13, c_BASE + 48'h30, 64'd0, 1'b1, 64'h7777_6666_5555_4444);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
